// File: rtl/bcd_counter_2d_pkg.sv
// -----------------------------------------------------------------------------
// bcd_counter_2d_pkg
// Shared decade constants and the BCD digit type. The downstream seven-segment
// decoder and its >9 comparator use the same constants.
// -----------------------------------------------------------------------------
package bcd_counter_2d_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_BASE = 4'd10;

    typedef logic [3:0] bcd_t;

    // Fold an arbitrary nibble into 0-9: values above 9 lose one decade.
    function automatic bcd_t bcd_correct(input logic [3:0] nibble);
        bcd_t result;
        if (nibble > BCD_MAX) begin
            result = nibble - BCD_BASE;
        end else begin
            result = nibble;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_counter_2d_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade register (0-9) with step, direction and parallel load.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset (digit -> 0)
//   step_i     advance the digit by one in direction dir_i
//   dir_i      1 = increment, 0 = decrement
//   load_i     parallel load, has priority over step_i
//   load_val_i raw nibble to load; values above 9 are folded back into 0-9
//   digit_o    registered digit value
//   co_o       combinational carry/borrow-out: step_i while at 9 (up) or 0 (down)
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_counter_2d_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       step_i,
    input  logic       dir_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] digit_o,
    output logic       co_o
);

    bcd_t digit_q;
    bcd_t digit_d;
    logic at_edge_s;

    // The digit is about to roll over if it sits at the end of its range.
    assign at_edge_s = dir_i ? (digit_q == BCD_MAX) : (digit_q == 4'd0);
    assign co_o      = step_i & at_edge_s;
    assign digit_o   = digit_q;

    // Next-digit selection: load beats step, step wraps within 0-9.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = bcd_correct(load_val_i);
        end else if (step_i) begin
            if (dir_i) begin
                digit_d = at_edge_s ? 4'd0 : (digit_q + 4'd1);
            end else begin
                digit_d = at_edge_s ? BCD_MAX : (digit_q - 4'd1);
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Decade register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_counter_2d.sv
// -----------------------------------------------------------------------------
// bcd_counter_2d
// Two-digit BCD up/down counter (00-99) paced by an internal tick prescaler,
// with synchronous parallel load. Feeds the HEX1:HEX0 seven-segment decoders.
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   en_i        enable for both prescaler and counting
//   up_i        direction, sampled on the tick edge (1 = up)
//   load_i      synchronous parallel load, overrides counting and En
//   load_val_i  [7:4] tens nibble, [3:0] units nibble
//   digit0_o    units digit (registered, 0-9)
//   digit1_o    tens digit (registered, 0-9)
//   wrap_o      one-cycle pulse after a 99->00 or 00->99 step
// Parameter:
//   TICK_DIV    enabled cycles per count step (>= 1)
// -----------------------------------------------------------------------------
module bcd_counter_2d
    import bcd_counter_2d_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       up_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [3:0] digit0_o,
    output logic [3:0] digit1_o,
    output logic       wrap_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;
    logic          wrap_q;
    logic          wrap_d;
    logic          tick_s;
    logic          count_s;
    logic          units_co_s;
    logic          tens_co_s;

    assign tick_s  = en_i & (p_q == P_LAST);
    // A load on a tick edge suppresses the count entirely.
    assign count_s = tick_s & ~load_i;

    // Prescaler next state: load restarts, enable advances, disable holds.
    always_comb begin
        p_d = p_q;
        if (load_i) begin
            p_d = '0;
        end else if (en_i) begin
            p_d = tick_s ? '0 : (p_q + PW'(1));
        end else begin
            p_d = p_q;
        end
    end

    // Wrap is the tens stage rolling over; count_s already excludes load.
    always_comb begin
        wrap_d = 1'b0;
        if (load_i) begin
            wrap_d = 1'b0;
        end else begin
            wrap_d = tens_co_s;
        end
    end

    // Prescaler and wrap-pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            wrap_q <= wrap_d;
        end
    end

    bcd_digit u_units (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .step_i     (count_s),
        .dir_i      (up_i),
        .load_i     (load_i),
        .load_val_i (load_val_i[3:0]),
        .digit_o    (digit0_o),
        .co_o       (units_co_s)
    );

    bcd_digit u_tens (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .step_i     (units_co_s),
        .dir_i      (up_i),
        .load_i     (load_i),
        .load_val_i (load_val_i[7:4]),
        .digit_o    (digit1_o),
        .co_o       (tens_co_s)
    );

    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_bcd_counter_2d.sv
// Bench for bcd_counter_2d (TICK_DIV = 4): directed scenarios plus random
// traffic, checked by a queue-based scoreboard against an arithmetic model.
module tb_bcd_counter_2d;

    localparam int unsigned TD = 4;

    typedef struct {
        int unsigned d1;
        int unsigned d0;
        int unsigned w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       wrap;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: counter value 0-99, prescaler phase, wrap flag.
    int unsigned m_val = 0;
    int unsigned m_p = 0;
    int unsigned m_w = 0;

    exp_t exp_q[$];

    bcd_counter_2d #(.TICK_DIV(TD)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .up_i       (up),
        .load_i     (load),
        .load_val_i (load_val),
        .digit0_o   (digit0),
        .digit1_o   (digit1),
        .wrap_o     (wrap)
    );

    always #5 clk = ~clk;

    function automatic int unsigned fold(input int unsigned n);
        return (n > 9) ? n - 10 : n;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit r, input bit e, input bit u,
                              input bit l, input int unsigned v);
        if (r) begin
            m_val = 0; m_p = 0; m_w = 0;
        end else if (l) begin
            m_val = fold(v / 16) * 10 + fold(v % 16);
            m_p = 0; m_w = 0;
        end else if (e) begin
            if (m_p == TD - 1) begin
                m_p = 0;
                if (u) begin
                    m_w = (m_val == 99) ? 1 : 0;
                    m_val = (m_val + 1) % 100;
                end else begin
                    m_w = (m_val == 0) ? 1 : 0;
                    m_val = (m_val + 99) % 100;
                end
            end else begin
                m_p = m_p + 1;
                m_w = 0;
            end
        end else begin
            m_w = 0;
        end
    endtask

    // Drive one cycle: inputs set between edges, expectation queued at the edge.
    task automatic apply(input bit r, input bit e, input bit u,
                         input bit l, input logic [7:0] v);
        exp_t x;
        rst = r; en = e; up = u; load = l; load_val = v;
        @(posedge clk);
        model_edge(r, e, u, l, int'(v));
        x.d1 = m_val / 10;
        x.d0 = m_val % 10;
        x.w  = m_w;
        exp_q.push_back(x);
        #1;
    endtask

    // Directed check against constants taken straight from the scenario.
    task automatic check_now(input string name, input int unsigned d1,
                             input int unsigned d0, input int unsigned w);
        vectors++;
        if (digit1 !== 4'(d1) || digit0 !== 4'(d0) || wrap !== 1'(w)) begin
            miscompares++;
            $display("FAIL %s: got %0d:%0d wrap=%0b, need %0d:%0d wrap=%0d",
                     name, digit1, digit0, wrap, d1, d0, w);
        end
    endtask

    // Monitor: every cycle the DUT presents a value; compare with the queue head.
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (digit1 !== 4'(x.d1) || digit0 !== 4'(x.d0) || wrap !== 1'(x.w)) begin
                miscompares++;
                $display("FAIL scoreboard @%0t: got %0d:%0d wrap=%0b, need %0d:%0d wrap=%0d",
                         $time, digit1, digit0, wrap, x.d1, x.d0, x.w);
            end
            if (digit0 > 4'd9 || digit1 > 4'd9) begin
                miscompares++;
                $display("FAIL range @%0t: got %0d:%0d, need digits 0-9",
                         $time, digit1, digit0);
            end
        end
    end

    initial begin
        // Scenario 1: count up from reset.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_now("reset", 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            if (i == 3)  check_now("up_edge3", 0, 0, 0);
            if (i == 4)  check_now("up_edge4", 0, 1, 0);
            if (i == 8)  check_now("up_edge8", 0, 2, 0);
            if (i == 12) check_now("up_edge12", 0, 3, 0);
        end

        // Scenario 2: 98 -> 99 -> 00 with one wrap pulse.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 8'h98);
        check_now("load_98", 9, 8, 0);
        for (int i = 1; i <= 8; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            if (i == 4) check_now("tick_99", 9, 9, 0);
            if (i == 8) check_now("wrap_up", 0, 0, 1);
        end
        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check_now("wrap_up_clear", 0, 0, 0);

        // Scenario 3: 00 -> 99 (wrap) -> 98, direction changing between ticks.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            apply(1'b0, 1'b1, (i == 4) ? 1'b0 : 1'b1, 1'b0, 8'h00);
        end
        check_now("wrap_down", 9, 9, 1);
        for (int i = 1; i <= 4; i++) begin
            apply(1'b0, 1'b1, (i == 4) ? 1'b0 : 1'b1, 1'b0, 8'h00);
            if (i == 1) check_now("wrap_down_clear", 9, 9, 0);
        end
        check_now("down_98", 9, 8, 0);

        // Scenario 4: load correction of out-of-range nibbles.
        apply(1'b0, 1'b1, 1'b1, 1'b1, 8'hAF);
        check_now("load_AF", 0, 5, 0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
        check_now("load_3C", 3, 2, 0);

        // Scenario 5: prescaler holds while disabled.
        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check_now("en_gap_hold", 3, 2, 0);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check_now("en_gap_tick", 3, 3, 0);

        // Scenario 6: load on the tick edge wins and restarts the prescaler.
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
        check_now("load_on_tick", 4, 2, 0);
        for (int i = 1; i <= 4; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            if (i == 3) check_now("after_load_hold", 4, 2, 0);
        end
        check_now("after_load_tick", 4, 3, 0);

        // Scenario 7: reset mid-count, together with a load.
        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        check_now("reset_mid", 0, 0, 0);

        // Random traffic, scoreboard-checked.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom),
                  ($urandom_range(0, 15) == 0),
                  8'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_counter_2d.md
# bcd_counter_2d

Two-digit BCD up/down counter (00–99) with a built-in tick prescaler and parallel load. It is the upstream stage of the board's seven-segment display path. Its two 4-bit digit outputs drive the existing BCD-to-7-segment decoders directly, so values on HEX1:HEX0 change at a human-visible rate. Counting is paced by an internal prescaler, so a fast board clock yields, e.g., a 1 Hz count.

## Interface
- TICK_DIV, default 50_000_000: enabled clock cycles per count step; legal range ≥1; 1 means count on every enabled cycle.
- Clock  input  1  rising-edge clock; single clock domain.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  count enable; gates both prescaler and counting.
- Up  input  1  direction: 1 = increment, 0 = decrement; sampled on the tick cycle.
- Load  input  1  synchronous parallel load; overrides counting.
- LoadVal  input  8  [7:4] tens digit, [3:0] units digit.
- Digit0  output  4  units digit, always 0–9.
- Digit1  output  4  tens digit, always 0–9.
- Wrap  output  1  one-cycle pulse on 99→00 (up) or 00→99 (down).

## Operation
- State: prescaler count P, width max(1, clog2(TICK_DIV)), plus the two digit registers.
- Priority per edge: Reset > Load > tick count > hold.
- Reset: P=0, Digit0=0, Digit1=0, Wrap=0.
- Load: digits take LoadVal with per-digit correction. A digit nibble >9 is stored as nibble−10 (10→0, 15→5). Load also sets P=0 and Wrap=0, and does not depend on En.
- Prescaler: when En=1 and no Load, P increments. The tick condition is En=1 and P==TICK_DIV−1; on a tick, P returns to 0. When En=0, P holds its value; the prescaler never clears on disable.
- Count on tick, Up=1: Digit0 increments. If Digit0 was 9, it becomes 0 and Digit1 increments. If the value was 99, the next value is 00 and Wrap=1.
- Count on tick, Up=0: Digit0 decrements. If Digit0 was 0, it becomes 9 and Digit1 decrements. If the value was 00, the next value is 99 and Wrap=1.
- Wrap is 0 on every cycle other than the tick cycle that wraps.
- Invariant: Digit0 and Digit1 never leave 0–9, under any input sequence.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Load asserted at edge k: the loaded digits are visible after edge k, with 1-cycle latency.
- With En held at 1 from the first cycle after reset, the first count occurs at the TICK_DIV-th enabled edge. Later counts occur every TICK_DIV enabled edges.
- Wrap is high for exactly the one cycle following the wrapping edge, aligned with the 00/99 digit value.
- Up changing between ticks has no effect; only its value on the tick edge matters.
- Load and tick on the same edge: Load wins, no count occurs, and the prescaler restarts at 0.
- Reset mid-count or during Load: all state returns to reset values at that edge.
- TICK_DIV=1: P is constant 0, and every En=1 cycle is a tick.

## Structure
- Shared package contents: BCD_MAX=4'd9, BCD_BASE=4'd10, and the 4-bit BCD digit type. The downstream decoder and its >9 comparator use the same constants.
- One sub-module, bcd_digit: a single decade register.
  - Inputs: step, dir, load, load value.
  - Outputs: digit, plus a carry/borrow-out flag. The flag is combinational and asserted when step=1 and the digit is at 9 (up) or 0 (down).
- Top level instantiates two bcd_digit chained by carry/borrow. The tens stage's flag drives Wrap. Prescaler logic lives in the top level.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then En=1, Up=1 for 12 cycles: Digit1:Digit0 reads 0:0 for cycles 1–3, 0:1 after edge 4, 0:2 after edge 8, 0:3 after edge 12; Wrap stays 0.
- Load LoadVal=8'h98, then En=1, Up=1 for 8 cycles: 9:9 after the 1st tick, 0:0 after the 2nd tick with a single Wrap pulse.
- Load 8'h00, then Up=0 for one tick: 9:9 with Wrap=1 for one cycle. Continue to the next tick: 9:8 with Wrap=0.
- Load 8'hAF: digits read 0:5. Load 8'h3C: digits read 3:2.
- En toggled 1,1,0,0,0,1,1 from P=0: the count steps only on the 4th enabled cycle (the last cycle of the sequence); P holds during En=0.
- Load asserted on a tick edge with LoadVal=8'h42: digits read 4:2, no count applied; the next count occurs 4 enabled cycles later. Reset asserted mid-count: all outputs read 0 after that edge.
